intersection_ctrl: RTL

//  Sequences a two-way intersection (NS/EW), each driven as a light_t RED/GREEN/YELLOW signal head.

---
 rtl/traffic_pkg.sv | 39 +++
 rtl/intersection_ctrl_phase_timer.sv | 31 +++
 rtl/intersection_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: signal-head colours, FSM phases,
// default timing and the phase-to-light lookup used by every signal head.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } light_t;

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR_A = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR_B = 3'd5
    } phase_t;

    localparam int DEF_GREEN_CYC  = 8;
    localparam int DEF_YELLOW_CYC = 3;
    localparam int DEF_ALLRED_CYC = 2;
    localparam int DEF_WALK_CYC   = 6;
    localparam int DEF_CNT_W      = 8;

    // Each head is non-RED only in its own green/yellow phase, so two greens can never coexist.
    function automatic light_t head_light(input phase_t p, input logic is_ns);
        light_t l;
        case (p)
            NS_G:    l = is_ns ? GREEN  : RED;
            NS_Y:    l = is_ns ? YELLOW : RED;
            EW_G:    l = is_ns ? RED    : GREEN;
            EW_Y:    l = is_ns ? RED    : YELLOW;
            default: l = RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Down-counting phase timer: expire flags the tick on which the count sits at zero;
// a load reprograms the count on that same edge.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] r_cnt;

    assign expire = tick && (r_cnt == {CNT_W{1'b0}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= RST_VAL;
        end else if (load) begin
            r_cnt <= value;
        end else if (tick && (r_cnt != {CNT_W{1'b0}})) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way intersection sequencer with all-red clearance and demand-based green extension.
// Optional pedestrian WALK service in the all-red phases when PED_WALK_EN is defined.
module intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_CYC  = DEF_GREEN_CYC,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int WALK_CYC   = DEF_WALK_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   tick,
    input  logic   ns_car,
    input  logic   ew_car,
    input  logic   ped_req,
    output light_t ns_light,
    output light_t ew_light,
    output logic   walk,
    output logic   ped_ack,
    output phase_t phase
);

    phase_t           r_phase;
    light_t           r_ns_light;
    light_t           r_ew_light;
    logic             r_walk;
    logic             r_ped_ack;
    phase_t           w_next_phase;
    logic             w_expire;
    logic             w_ped_pend;
    logic             w_ped_take;
    logic [CNT_W-1:0] w_load_val;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(ALLRED_CYC - 1))
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .load   (w_expire),
        .value  (w_load_val),
        .expire (w_expire)
    );

`ifdef PED_WALK_EN
    logic r_ped_pend;

    // A request arriving on the accepting edge survives the clear and is served next time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ped_pend <= 1'b0;
        end else begin
            r_ped_pend <= ped_req | (r_ped_pend & ~w_ped_take);
        end
    end

    assign w_ped_pend = r_ped_pend;
`else
    logic w_unused_ped;

    assign w_unused_ped = ped_req;
    assign w_ped_pend   = 1'b0;
`endif

    always_comb begin
        case (r_phase)
            NS_G:    w_next_phase = (ew_car || w_ped_pend) ? NS_Y : NS_G;
            NS_Y:    w_next_phase = AR_A;
            AR_A:    w_next_phase = EW_G;
            EW_G:    w_next_phase = (ns_car || w_ped_pend) ? EW_Y : EW_G;
            EW_Y:    w_next_phase = AR_B;
            AR_B:    w_next_phase = NS_G;
            default: w_next_phase = AR_B;
        endcase
    end

    assign w_ped_take = w_expire && w_ped_pend &&
                        ((w_next_phase == AR_A) || (w_next_phase == AR_B));

    always_comb begin
        case (w_next_phase)
            NS_G, EW_G: w_load_val = CNT_W'(GREEN_CYC - 1);
            NS_Y, EW_Y: w_load_val = CNT_W'(YELLOW_CYC - 1);
            AR_A, AR_B: w_load_val = w_ped_take ? CNT_W'(WALK_CYC - 1) : CNT_W'(ALLRED_CYC - 1);
            default:    w_load_val = CNT_W'(ALLRED_CYC - 1);
        endcase
    end

    // Lights and walk are recomputed from the phase being entered, so they move on the expiring edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase    <= AR_B;
            r_ns_light <= RED;
            r_ew_light <= RED;
            r_walk     <= 1'b0;
            r_ped_ack  <= 1'b0;
        end else begin
            r_ped_ack <= w_ped_take;
            if (w_expire) begin
                r_phase    <= w_next_phase;
                r_ns_light <= head_light(w_next_phase, 1'b1);
                r_ew_light <= head_light(w_next_phase, 1'b0);
                r_walk     <= w_ped_take;
            end else begin
                r_phase    <= r_phase;
                r_ns_light <= r_ns_light;
                r_ew_light <= r_ew_light;
                r_walk     <= r_walk;
            end
        end
    end

    assign phase    = r_phase;
    assign ns_light = r_ns_light;
    assign ew_light = r_ew_light;
    assign walk     = r_walk;
    assign ped_ack  = r_ped_ack;

endmodule
